audio_scheduler: RTL and testbench

//  Owns the speaker path. Picks the background track from game state. Sequences it beat by beat from an internal note table.
//  Pre-empts the track with one-shot sound effects and applies volume/mute.

---
 rtl/audio_scheduler.sv | 114 +++++++++++
 tb/tb_audio_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/audio_scheduler.sv
// audio_scheduler: background track sequencer with one-shot effects and volume/mute; define AUDIO_SCHED_BGM_PAUSE_EN to freeze BGM while an effect plays
module audio_scheduler #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BEAT_HZ   = 8,
  parameter int SFX_HZ    = 16,
  parameter int TRACK_LEN = 64,
  parameter int AMP_STEP  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        mute,
  input  logic [3:0]  state,
  input  logic [1:0]  sfx_req,
  output logic [11:0] note_freq,
  output logic [15:0] amplitude,
  output logic [2:0]  volume,
  output logic        sfx_busy,
  output logic [5:0]  beat_idx
);
  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
  localparam int SFX_DIV  = CLK_HZ / SFX_HZ;
  localparam int BW = $clog2(BEAT_DIV + 1);
  localparam int SW = $clog2(SFX_DIV + 1);
  typedef enum logic {BGM, SFX} fsm_t;
  fsm_t fsm, fsm_d;
  logic [BW-1:0] beat_cnt, beat_cnt_d;
  logic [SW-1:0] sfx_cnt, sfx_cnt_d;
  logic [5:0] beat_idx_d;
  logic [3:0] prev_state;
  logic [1:0] sfx_id, sfx_id_d, sfx_step, sfx_step_d;
  logic [2:0] vol_d;
  logic [11:0] freq_sel;
  logic st_chg, beat_tick, sfx_wrap, hold;
  function automatic logic [11:0] bgm_note(input logic [2:0] t, input logic [1:0] i);
    logic [47:0] row;
    row = t == 3'd0 ? {12'd523, 12'd392, 12'd330, 12'd262}
        : t == 3'd1 ? {12'd587, 12'd440, 12'd349, 12'd294}
        : t == 3'd2 ? {12'd659, 12'd494, 12'd392, 12'd330}
        : t == 3'd3 ? {12'd392, 12'd294, 12'd247, 12'd196}
        : t == 3'd4 ? {12'd0, 12'd220, 12'd0, 12'd220}
        : t == 3'd5 ? {12'd0, 12'd523, 12'd0, 12'd440}
        : '0;
    return row[12*i +: 12];
  endfunction
  function automatic logic [11:0] sfx_note(input logic [1:0] id, input logic [1:0] i);
    logic [47:0] row;
    row = id == 2'd1 ? {12'd1319, 12'd1319, 12'd988, 12'd988}
        : id == 2'd2 ? {12'd196, 12'd196, 12'd196, 12'd196}
        : id == 2'd3 ? {12'd1047, 12'd784, 12'd659, 12'd523}
        : '0;
    return row[12*i +: 12];
  endfunction
`ifdef AUDIO_SCHED_BGM_PAUSE_EN
  assign hold = fsm == SFX;
`else
  assign hold = 1'b0;
`endif
  // next-state for beat timing, effect sequencing, volume and the selected tone
  always_comb begin
    st_chg = state != prev_state;
    beat_tick = beat_cnt == BW'(BEAT_DIV - 1);
    sfx_wrap = sfx_cnt == SW'(SFX_DIV - 1);
    beat_cnt_d = st_chg ? '0 : hold ? beat_cnt : beat_tick ? '0 : beat_cnt + 1'b1;
    beat_idx_d = st_chg ? '0 : (hold || !beat_tick) ? beat_idx
               : beat_idx == 6'(TRACK_LEN - 1) ? '0 : beat_idx + 1'b1;
    fsm_d = fsm;
    sfx_id_d = sfx_id;
    sfx_step_d = sfx_step;
    sfx_cnt_d = sfx_cnt;
    if (sfx_req != 2'd0) begin
      fsm_d = SFX;
      sfx_id_d = sfx_req;
      sfx_step_d = '0;
      sfx_cnt_d = '0;
    end else if (fsm == SFX) begin
      sfx_cnt_d = sfx_wrap ? '0 : sfx_cnt + 1'b1;
      sfx_step_d = sfx_wrap ? sfx_step + 1'b1 : sfx_step;
      fsm_d = (sfx_wrap && sfx_step == 2'd3) ? BGM : SFX;
    end
    vol_d = (vol_up && !vol_down && volume != 3'd5) ? volume + 3'd1
          : (vol_down && !vol_up && volume != 3'd0) ? volume - 3'd1 : volume;
    freq_sel = fsm_d == SFX ? sfx_note(sfx_id_d, sfx_step_d) : bgm_note(state[2:0], beat_idx_d[1:0]);
  end
  // state and registered outputs; reset aborts any effect immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= BGM;
      beat_cnt <= '0;
      beat_idx <= '0;
      sfx_cnt <= '0;
      sfx_step <= '0;
      sfx_id <= '0;
      prev_state <= '0;
      volume <= 3'd3;
      note_freq <= '0;
      amplitude <= '0;
      sfx_busy <= 1'b0;
    end else begin
      fsm <= fsm_d;
      beat_cnt <= beat_cnt_d;
      beat_idx <= beat_idx_d;
      sfx_cnt <= sfx_cnt_d;
      sfx_step <= sfx_step_d;
      sfx_id <= sfx_id_d;
      prev_state <= state;
      volume <= vol_d;
      note_freq <= freq_sel;
      amplitude <= (mute || vol_d == 3'd0 || freq_sel == 12'd0) ? '0 : 16'(vol_d * AMP_STEP);
      sfx_busy <= fsm_d == SFX;
    end
  end
endmodule

// File: tb/tb_audio_scheduler.sv
// tb_audio_scheduler: scoreboard bench for audio_scheduler at CLK_HZ=64, BEAT_DIV=16, SFX_DIV=8
module tb_audio_scheduler;
  logic clk = 0, rst = 0, vol_up = 0, vol_down = 0, mute = 0;
  logic [3:0] state = 0;
  logic [1:0] sfx_req = 0;
  logic [11:0] note_freq;
  logic [15:0] amplitude;
  logic [2:0] volume;
  logic sfx_busy;
  logic [5:0] beat_idx;
  int errors = 0, checks = 0;
  typedef struct {
    int freq;
    int amp;
    int vol;
    int busy;
    int idx;
    bit fv;
  } exp_t;
  exp_t sb[$];
  int k = 0, sk = 0, vol_m = 3, id_m = 0;
  bit act = 0;
  logic [3:0] st_m = 0;

  audio_scheduler #(.CLK_HZ(64), .BEAT_HZ(4), .SFX_HZ(8)) dut (
    .clk(clk), .rst(rst), .vol_up(vol_up), .vol_down(vol_down), .mute(mute),
    .state(state), .sfx_req(sfx_req), .note_freq(note_freq), .amplitude(amplitude),
    .volume(volume), .sfx_busy(sfx_busy), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int bgm(input int t, input int b);
    if (t == 0) return b == 0 ? 262 : b == 1 ? 330 : b == 2 ? 392 : 523;
    if (t == 4) return b % 2 == 0 ? 220 : 0;
    return 0;
  endfunction

  function automatic int sfx(input int id, input int s);
    if (id == 1) return s < 2 ? 988 : 1319;
    if (id == 2) return 196;
    return s == 0 ? 523 : s == 1 ? 659 : s == 2 ? 784 : 1047;
  endfunction

  // one clock: drive inputs, push the expected outputs, then pop and compare after the edge
  task automatic cyc(input logic [1:0] req, input logic up, input logic dn, input logic mt, input logic [3:0] st);
    exp_t e;
    int f;
    bit was_act;
    was_act = act;
    sfx_req = req; vol_up = up; vol_down = dn; mute = mt; state = st;
    if (st != st_m) k = 0;
`ifdef AUDIO_SCHED_BGM_PAUSE_EN
    else if (!was_act) k++;
`else
    else k++;
`endif
    st_m = st;
    if (up && !dn && vol_m < 5) vol_m++;
    else if (dn && !up && vol_m > 0) vol_m--;
    if (req != 0) begin act = 1; id_m = req; sk = 0; end
    else if (act) begin sk++; if (sk == 32) act = 0; end
    f = act ? sfx(id_m, sk / 8) : bgm(int'(st[2:0]), k / 16);
    e.fv = act || (k / 16) < 4 || st[2:1] == 2'b11;
    e.freq = f;
    e.amp = (mt || vol_m == 0 || f == 0) ? 0 : vol_m * 5000;
    e.vol = vol_m;
    e.busy = act;
    e.idx = (k / 16) % 64;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.fv) begin
      check("note_freq", int'(note_freq), e.freq);
      check("amplitude", int'(amplitude), e.amp);
    end
    check("volume", int'(volume), e.vol);
    check("sfx_busy", int'(sfx_busy), e.busy);
    check("beat_idx", int'(beat_idx), e.idx);
  endtask

  task automatic idle(input int n, input logic [3:0] st);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, st);
  endtask

  initial begin
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_freq", int'(note_freq), 0);
    check("rst_amp", int'(amplitude), 0);
    check("rst_vol", int'(volume), 3);
    check("rst_busy", int'(sfx_busy), 0);
    check("rst_idx", int'(beat_idx), 0);
    rst = 0;
    idle(70, 0);
    idle(20, 4);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    idle(2, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    idle(3, 6);
    idle(18, 0);
    cyc(1, 0, 0, 0, 0);
    idle(40, 0);
    cyc(0, 0, 0, 0, 4);
    idle(5, 0);
    cyc(1, 0, 0, 0, 0);
    idle(10, 0);
    cyc(3, 0, 0, 0, 0);
    idle(40, 0);
    cyc(0, 0, 0, 0, 4);
    cyc(2, 0, 0, 0, 0);
    idle(31, 0);
    cyc(2, 0, 0, 0, 0);
    idle(31, 0);
    cyc(1, 0, 0, 0, 0);
    idle(36, 0);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] st;
      logic [1:0] rq;
      int pick;
      st = st_m;
      if ($urandom_range(0, 19) == 0) begin
        pick = $urandom_range(0, 2);
        st = pick == 0 ? 4'd0 : pick == 1 ? 4'd4 : 4'd6;
      end
      rq = $urandom_range(0, 24) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc(rq, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, st);
    end
    idle(2, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    idle(5, 0);
    rst = 1;
    #1;
    check("arst_freq", int'(note_freq), 0);
    check("arst_amp", int'(amplitude), 0);
    check("arst_busy", int'(sfx_busy), 0);
    check("arst_vol", int'(volume), 3);
    check("arst_idx", int'(beat_idx), 0);
    state = 0;
    @(posedge clk);
    #1;
    rst = 0;
    k = 0; st_m = 0; vol_m = 3; act = 0; sk = 0;
    idle(20, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
